// File: rtl/data_break_arbiter.sv
// Data-break arbiter: grants one of four devices a memory cycle by handshaking with the
// CPU state machine through the DB0/DB1 states, with a watchdog on the request phase.
module data_break_arbiter #(
  parameter logic [4:0] DB0 = 5'd12,
  parameter logic [4:0] DB1 = 5'd13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic [0:3]  req,
  input  logic [0:3]  dir,
  input  logic [0:47] dev_addr,
  output logic        data_break,
  output logic        to_disk,
  output logic [0:11] db_addr,
  output logic [0:3]  grant,
  output logic [0:3]  ack,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, ACK} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [1:0]  idx_q, idx_d;
  logic        dir_q, dir_d;
  logic [0:11] addr_q, addr_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [0:3]  excl_q, excl_d;
  logic        timeout_q, timeout_d;
  logic        data_break_q, data_break_d;
  logic        to_disk_q, to_disk_d;
  logic [0:11] db_addr_q, db_addr_d;
  logic [0:3]  grant_q, grant_d;
  logic [0:3]  ack_q, ack_d;

  logic [0:3]  eligible;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic        pick_dir;
  logic [0:11] pick_addr;
  logic [0:3]  oh;
  logic        xfer;

  // Lowest-numbered eligible request wins; the just-acked device sits out one cycle.
  always_comb begin
    eligible   = req & ~excl_q;
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    pick_dir   = 1'b0;
    pick_addr  = '0;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
        pick_dir   = dir[i];
        pick_addr  = dev_addr[i*12 +: 12];
      end
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    excl_d    = '0;
    case (fsm_q)
      IDLE: begin
        if (pick_found) begin
          fsm_d  = REQ;
          idx_d  = pick_idx;
          dir_d  = pick_dir;
          addr_d = pick_addr;
          wdog_d = 8'd254;
        end
      end
      REQ: begin
        if (state == DB0) begin
          fsm_d = SERVE;
        end else if (!req[idx_q]) begin
          fsm_d = IDLE;
        end else if (wdog_q == 8'd0) begin
          // 255th request cycle without DB0
          fsm_d     = IDLE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q - 8'd1;
        end
      end
      SERVE: begin
        if (state != DB0 && state != DB1) fsm_d = ACK;
      end
      ACK: begin
        fsm_d         = IDLE;
        excl_d[idx_q] = 1'b1;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    oh           = '0;
    oh[idx_d]    = 1'b1;
    xfer         = (fsm_d == REQ) || (fsm_d == SERVE);
    data_break_d = xfer;
    to_disk_d    = xfer ? dir_d : 1'b0;
    db_addr_d    = xfer ? addr_d : '0;
    grant_d      = (fsm_d != IDLE) ? oh : '0;
    ack_d        = (fsm_d == ACK) ? oh : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= IDLE;
      idx_q        <= 2'd0;
      dir_q        <= 1'b0;
      addr_q       <= '0;
      wdog_q       <= 8'd0;
      excl_q       <= '0;
      timeout_q    <= 1'b0;
      data_break_q <= 1'b0;
      to_disk_q    <= 1'b0;
      db_addr_q    <= '0;
      grant_q      <= '0;
      ack_q        <= '0;
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      addr_q       <= addr_d;
      wdog_q       <= wdog_d;
      excl_q       <= excl_d;
      timeout_q    <= timeout_d;
      data_break_q <= data_break_d;
      to_disk_q    <= to_disk_d;
      db_addr_q    <= db_addr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
    end
  end

  assign data_break = data_break_q;
  assign to_disk    = to_disk_q;
  assign db_addr    = db_addr_q;
  assign grant      = grant_q;
  assign ack        = ack_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_data_break_arbiter.sv
// Directed bench for data_break_arbiter: each task drives one scenario and checks the
// packed output vector against hand-computed values one cycle at a time.
module tb_data_break_arbiter;

  localparam logic [4:0] S_DB0   = 5'd12;
  localparam logic [4:0] S_DB1   = 5'd13;
  localparam logic [4:0] S_F0    = 5'd0;
  localparam logic [4:0] S_OTHER = 5'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  state = S_OTHER;
  logic [0:3]  req = '0;
  logic [0:3]  dir = '0;
  logic [0:47] dev_addr = '0;
  logic        data_break, to_disk, timeout;
  logic [0:11] db_addr;
  logic [0:3]  grant, ack;

  logic [22:0] outs;
  logic [22:0] e;
  int vec = 0;
  int errs = 0;

  data_break_arbiter #(.DB0(S_DB0), .DB1(S_DB1)) dut (
    .clk(clk), .reset(reset), .state(state), .req(req), .dir(dir), .dev_addr(dev_addr),
    .data_break(data_break), .to_disk(to_disk), .db_addr(db_addr),
    .grant(grant), .ack(ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign outs = {data_break, to_disk, db_addr, grant, ack, timeout};

  function automatic logic [22:0] pk(input logic db, input logic td, input logic [11:0] a,
                                     input logic [3:0] g, input logic [3:0] k, input logic t);
    return {db, td, a, g, k, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; dir = 4'b1111;
    dev_addr = {12'o1234, 12'o1111, 12'o2222, 12'o3333};
    tick(); tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL reset_hold got=%h exp=%h", outs, e); end
    reset = 1'b0; req = 4'b1000; dir = 4'b0000;
    tick();
    e = pk(1, 0, 12'o1234, 4'b1000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL reset_first_arb got=%h exp=%h", outs, e); end
    req = 4'b0000;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL reset_release got=%h exp=%h", outs, e); end
  endtask

  task automatic test_single();
    req = 4'b0100; dir = 4'b0100; state = S_OTHER;
    dev_addr = {12'o1234, 12'o4000, 12'o2222, 12'o3333};
    tick();
    e = pk(1, 1, 12'o4000, 4'b0100, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL single_req got=%h exp=%h", outs, e); end
    state = S_DB0;
    tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL single_db0 got=%h exp=%h", outs, e); end
    // dir/dev_addr changes after latching must not show up
    state = S_DB1; dir = 4'b0000; dev_addr = {4{12'o7777}};
    tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL single_db1 got=%h exp=%h", outs, e); end
    state = S_F0;
    tick();
    e = pk(0, 0, 12'o0, 4'b0100, 4'b0100, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL single_ack got=%h exp=%h", outs, e); end
    state = S_OTHER; req = 4'b0000;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL single_ack_once got=%h exp=%h", outs, e); end
  endtask

  task automatic test_priority();
    req = 4'b0011; dir = 4'b0010; state = S_OTHER;
    dev_addr = {12'o1234, 12'o1111, 12'o2222, 12'o3333};
    tick();
    e = pk(1, 1, 12'o2222, 4'b0010, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_first got=%h exp=%h", outs, e); end
    state = S_DB0; tick();
    state = S_F0;  tick();
    e = pk(0, 0, 12'o0, 4'b0010, 4'b0010, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_ack2 got=%h exp=%h", outs, e); end
    state = S_OTHER;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_gap got=%h exp=%h", outs, e); end
    tick();
    e = pk(1, 0, 12'o3333, 4'b0001, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_second got=%h exp=%h", outs, e); end
    req = 4'b1011;
    tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_no_preempt got=%h exp=%h", outs, e); end
    state = S_DB0; tick();
    state = S_F0; req = 4'b0000; tick();
    e = pk(0, 0, 12'o0, 4'b0001, 4'b0001, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL prio_ack3 got=%h exp=%h", outs, e); end
    state = S_OTHER; tick();
  endtask

  task automatic test_withdraw();
    req = 4'b1000; dir = 4'b1000; state = S_OTHER;
    tick();
    e = pk(1, 1, 12'o1234, 4'b1000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL wd_req got=%h exp=%h", outs, e); end
    repeat (4) tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL wd_hold5 got=%h exp=%h", outs, e); end
    req = 4'b0000;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL wd_idle got=%h exp=%h", outs, e); end
    tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL wd_no_ack got=%h exp=%h", outs, e); end
  endtask

  task automatic test_sticky();
    req = 4'b1000; dir = 4'b0000; state = S_OTHER;
    tick();
    state = S_DB0; tick();
    state = S_F0;  tick();
    e = pk(0, 0, 12'o0, 4'b1000, 4'b1000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL sticky_ack got=%h exp=%h", outs, e); end
    state = S_OTHER;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL sticky_masked got=%h exp=%h", outs, e); end
    tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL sticky_rearb got=%h exp=%h", outs, e); end
    tick();
    e = pk(1, 0, 12'o1234, 4'b1000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL sticky_regrant got=%h exp=%h", outs, e); end
    req = 4'b0000; tick();
  endtask

  task automatic test_watchdog();
    req = 4'b0001; dir = 4'b0001; state = S_OTHER;
    tick();
    e = pk(1, 1, 12'o3333, 4'b0001, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL wdog_c1 got=%h exp=%h", outs, e); end
    repeat (254) tick();
    vec++;
    if (outs !== e) begin errs++; $display("FAIL wdog_c255 got=%h exp=%h", outs, e); end
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 1); vec++;
    if (outs !== e) begin errs++; $display("FAIL wdog_fire got=%h exp=%h", outs, e); end
    req = 4'b0100; dir = 4'b0000;
    tick();
    e = pk(1, 0, 12'o1111, 4'b0100, 4'b0000, 1); vec++;
    if (outs !== e) begin errs++; $display("FAIL wdog_traffic got=%h exp=%h", outs, e); end
    state = S_DB0; tick();
    state = S_F0; req = 4'b0000; tick();
    e = pk(0, 0, 12'o0, 4'b0100, 4'b0100, 1); vec++;
    if (outs !== e) begin errs++; $display("FAIL wdog_sticky got=%h exp=%h", outs, e); end
    state = S_OTHER; tick();
  endtask

  task automatic test_reset_mid_serve();
    req = 4'b0010; dir = 4'b0010; state = S_OTHER;
    tick();
    state = S_DB0; tick();
    state = S_DB1; tick();
    e = pk(1, 1, 12'o2222, 4'b0010, 4'b0000, 1); vec++;
    if (outs !== e) begin errs++; $display("FAIL rst_serve got=%h exp=%h", outs, e); end
    reset = 1'b1;
    tick();
    e = pk(0, 0, 12'o0, 4'b0000, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL rst_mid got=%h exp=%h", outs, e); end
    reset = 1'b0; state = S_OTHER;
    tick();
    e = pk(1, 1, 12'o2222, 4'b0010, 4'b0000, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL rst_after_req got=%h exp=%h", outs, e); end
    state = S_DB0; tick();
    state = S_F0; req = 4'b0000; tick();
    e = pk(0, 0, 12'o0, 4'b0010, 4'b0010, 0); vec++;
    if (outs !== e) begin errs++; $display("FAIL rst_after_ack got=%h exp=%h", outs, e); end
    state = S_OTHER; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_withdraw();
    test_sticky();
    test_watchdog();
    test_reset_mid_serve();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/data_break_arbiter.md
DATA_BREAK_ARBITER -- requirements
Module: data_break_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, both listed first among the ports.
REQ-002 SHALL have port clk, input, 1 bit: system clock; every flop updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port state, input, 5 bits: current CPU state machine state; the codes DB0 and DB1 come from the shared parameter include.
REQ-005 SHALL have port req, input, [0:3]: data-break request per device, level-sensitive; index 0 has highest priority.
REQ-006 SHALL have port dir, input, [0:3]: per-device direction; 1 = memory-to-device.
REQ-007 SHALL have port dev_addr, input, [0:47]: four 12-bit device addresses; device i occupies bits [12i : 12i+11].
REQ-008 SHALL have port data_break, output, 1 bit: break request to the CPU state machine.
REQ-009 SHALL have port to_disk, output, 1 bit: direction of the granted transfer, to the CPU state machine.
REQ-010 SHALL have port db_addr, output, [0:11]: memory address of the granted transfer.
REQ-011 SHALL have port grant, output, [0:3]: one-hot grant, or all zero.
REQ-012 SHALL have port ack, output, [0:3]: one-cycle completion pulse per device.
REQ-013 SHALL have port timeout, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ, SERVE and ACK.
REQ-015 In IDLE with any req bit high, SHALL on the next edge latch three values and move to REQ: the index of the lowest-numbered active req, its dir bit and its dev_addr field.
REQ-016 In IDLE with no req bit high, SHALL stay in IDLE with data_break=0 and grant=0.
REQ-017 In REQ, SERVE and ACK, SHALL hold grant one-hot at the latched index.
REQ-018 In REQ, SHALL hold data_break=1, to_disk=latched dir and db_addr=latched address, all stable until the FSM leaves SERVE.
REQ-019 In REQ, a higher-priority req arriving later SHALL NOT preempt the latched grant.
REQ-020 In REQ, when state==DB0, SHALL move to SERVE on the next edge.
REQ-021 In REQ, if the granted req drops before DB0 is seen, SHALL return to IDLE on the next edge with no ack pulse, and data_break SHALL be 0 in that next cycle.
REQ-022 In REQ, SHALL count cycles in an 8-bit counter; after 255 cycles without DB0, SHALL set timeout=1 and return to IDLE with no ack pulse.
REQ-023 In SERVE, SHALL keep data_break=1 while state is DB0 or DB1.
REQ-024 In SERVE, SHALL move to ACK on the first cycle where state is neither DB0 nor DB1.
REQ-025 In ACK, SHALL drive ack[index]=1 for exactly one cycle, with data_break=0 and to_disk=0, then move to IDLE.
REQ-026 In the IDLE cycle immediately after ACK, SHALL exclude the just-acked index from arbitration, so a device slow to drop req cannot be serviced twice.
REQ-027 SHALL allow a second transfer to be granted no sooner than 2 cycles after an ack pulse: ACK to IDLE to REQ.
REQ-028 SHALL never assert more than one bit of grant or ack at a time.
REQ-029 SHALL register all outputs; no output depends combinationally on any input.
REQ-030 SHALL clear timeout only on reset.
REQ-031 SHALL ignore dir and dev_addr except on the IDLE-to-REQ latching edge.

Reset
REQ-032 On reset=1 at any rising edge, including mid-transfer, SHALL on that edge enter IDLE and drive data_break=0, to_disk=0, db_addr=0, grant=0, ack=0 and timeout=0, and clear the watchdog counter and the exclusion mask.
REQ-033 Throughout reset, SHALL ignore req.
REQ-034 In the first cycle after reset deasserts, SHALL arbitrate normally.

Verification
REQ-035 Single request: req=0100, dir=0100, addr1=12'o4000, then state REQ to DB0 to DB1 to F0 -> grant=0100, data_break=1 from cycle 2, to_disk=1, db_addr=12'o4000, ack=0100 for exactly one cycle after the F0 cycle.
REQ-036 Priority: req=0011 in the same cycle, and both stay high until acked -> device 2 is granted first; device 3 is granted 2 cycles after ack[2]; no preemption when req[0] rises during device 3's REQ.
REQ-037 Withdrawal: req=1000, then req=0000 after 5 cycles with no DB0 -> next cycle is IDLE, data_break=0, no ack, timeout=0.
REQ-038 Watchdog: req=0001 held, state never DB0 -> timeout=1 after 255 REQ cycles; returns to IDLE; the sticky flag survives further traffic.
REQ-039 Reset mid-SERVE: assert reset while state=DB1 -> next cycle all outputs zero, FSM in IDLE; a later req is served normally.
REQ-040 Sticky req: req[0] held high through ack -> not re-granted in the IDLE cycle right after ack; re-granted one cycle later.
